// File: rtl/shift_norm_pkg.sv
// Shared types and constants for the shift normalizer family.
// The normalizer FSM state and the operand-mode encodings live here.
package shift_norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } norm_state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/norm_window_check.sv
// Combinational test for one binary-search stage: can y be shifted left by 2^k
// without losing significance (leading zeros unsigned, redundant sign bits signed)?
module norm_window_check
    import shift_norm_pkg::*;
#(
    parameter int D_SIZE = 16
) (
    input  logic [D_SIZE-1:0]         y,
    input  logic [$clog2(D_SIZE)-1:0] k,
    input  logic                      mode,
    output logic                      fire
);

    logic [D_SIZE-1:0] win;
    logic [D_SIZE-1:0] top_mask;
    logic [D_SIZE-1:0] sgn_mask;
    logic [D_SIZE-1:0] sgn_diff;

    always_comb begin
        win      = {{(D_SIZE-1){1'b0}}, 1'b1} << k;
        // top W bits for the zero test, top W+1 bits for the sign-equality test
        top_mask = ~({D_SIZE{1'b1}} >> win);
        sgn_mask = ~({D_SIZE{1'b1}} >> (win + {{(D_SIZE-1){1'b0}}, 1'b1}));
        sgn_diff = y ^ {D_SIZE{y[D_SIZE-1]}};
        if (mode == MODE_SIGNED) begin
            fire = ((sgn_diff & sgn_mask) == '0);
        end else begin
            fire = ((y & top_mask) == '0);
        end
    end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: binary search for the normalizing left shift, one
// stage per clock (largest first), with valid/ready on both sides.
module shift_normalizer
    import shift_norm_pkg::*;
#(
    parameter int D_SIZE = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [D_SIZE-1:0]         x_in,
    input  logic                      mode_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    output logic [D_SIZE-1:0]         y_out,
    output logic [$clog2(D_SIZE)-1:0] s_out,
    output logic                      zf_out,
    output logic                      valid_out,
    input  logic                      ready_in
);

    localparam int L = $clog2(D_SIZE);

    norm_state_t       state_q, state_d;
    logic [D_SIZE-1:0] y_q, y_d;
    logic [L-1:0]      s_q, s_d;
    logic [L-1:0]      k_q, k_d;
    logic              mode_q, mode_d;
    logic              zf_q, zf_d;

    logic              fire;
    logic [D_SIZE-1:0] win;

    norm_window_check #(.D_SIZE(D_SIZE)) u_check (
        .y    (y_q),
        .k    (k_q),
        .mode (mode_q),
        .fire (fire)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        s_d     = s_q;
        k_d     = k_q;
        mode_d  = mode_q;
        zf_d    = zf_q;
        win     = {{(D_SIZE-1){1'b0}}, 1'b1} << k_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    y_d     = x_in;
                    mode_d  = mode_in;
                    s_d     = '0;
                    zf_d    = (x_in == '0);
                    k_d     = L'(L - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fire) begin
                    y_d      = y_q << win;
                    s_d[k_q] = 1'b1;
                end
                // fixed L-edge latency regardless of data
                if (k_q == '0) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            DONE: begin
                if (ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            y_q     <= '0;
            s_q     <= '0;
            k_q     <= '0;
            mode_q  <= MODE_UNSIGNED;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            s_q     <= s_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            zf_q    <= zf_d;
        end
    end

    assign ready_out = (state_q == IDLE);
    assign valid_out = (state_q == DONE);
    assign y_out     = y_q;
    assign s_out     = s_q;
    assign zf_out    = zf_q;

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Multi-cycle normalizer that runs the barrel-shift problem in reverse. Given an operand, it finds the left-shift amount that normalizes it and returns both the shifted value and that amount.
- Works as a binary search over the log2(D_SIZE) shift stages, resolving one stage per clock, largest stage first.
- Sits upstream of the barrel shifter in the shift/ALU datapath. It feeds s_out back as a shift amount and supports unsigned (leading-zero) and signed (redundant-sign-bit) modes.
- Uses a valid/ready handshake on both sides.

Parameters:
- D_SIZE, 16, operand width in bits; must be a power of two and at least 4. L = $clog2(D_SIZE).

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- x_in  input  D_SIZE  operand.
- mode_in  input  1  0 = unsigned (count leading zeros); 1 = signed (count redundant sign bits).
- valid_in  input  1  request valid.
- ready_out  output  1  block can accept a request.
- y_out  output  D_SIZE  normalized value (x shifted left by s_out, zero-filled).
- s_out  output  L  shift amount applied.
- zf_out  output  1  operand was zero.
- valid_out  output  1  result valid.
- ready_in  input  1  consumer accepts result.

Behaviour:
- Reset state (rst_n_in low, asynchronous, any state): state=IDLE, y_out=0, s_out=0, zf_out=0, valid_out=0, ready_out=1.
- States:
  - IDLE: ready_out=1, valid_out=0.
  - RUN: ready_out=0, valid_out=0.
  - DONE: ready_out=0, valid_out=1.
- IDLE to RUN: on an edge with valid_in=1.
  - Capture y_reg=x_in, mode_reg=mode_in, s_reg=0, zf_out=(x_in==0), stage counter k=L-1.
  - Later changes on x_in/mode_in are ignored.
- Each RUN edge processes stage k with window W = 2^k:
  - Unsigned: if the top W bits of y_reg are all zero, y_reg <= y_reg<<W and s_reg[k] <= 1.
  - Signed: if the top W+1 bits of y_reg are all equal, y_reg <= y_reg<<W and s_reg[k] <= 1.
  - Otherwise y_reg and s_reg are unchanged.
  - If k==0, go to DONE; else k <= k-1.
- Latency: exactly L RUN edges. valid_out rises after the L-th edge following the accept edge, independent of data value (D_SIZE=16: 4 edges).
- DONE to IDLE: on an edge with ready_in=1. Outputs hold stable while ready_in=0. There is no accept in DONE; throughput is one request per L+2 cycles minimum.
- y_out/s_out are driven from y_reg/s_reg. They are meaningful only when valid_out=1 but are deterministic at all times.
- Zero operand, either mode: every stage fires, so y_out=0, s_out=D_SIZE-1 (all ones), zf_out=1.
- Signed all-ones operand (-1): s_out=D_SIZE-1, y_out=1 followed by zeros (0x8000 for D_SIZE=16), zf_out=0.
- Already-normalized operand (unsigned MSB=1, or signed bit[D-1]!=bit[D-2]): s_out=0, y_out=x_in, latency still L.
- valid_in while in RUN/DONE: ignored; the request is not captured.
- Reset mid-RUN or mid-DONE: the in-flight result is discarded, with no partial valid_out.

Decomposition:
- Package shift_norm_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} norm_state_t.
  - Mode constants MODE_UNSIGNED=1'b0, MODE_SIGNED=1'b1.
- Sub-module norm_window_check #(D_SIZE):
  - Combinational inputs: y, k, mode.
  - Output: fire, meaning the top 2^k bits are zero (unsigned) or the top 2^k+1 bits are equal (signed).
  - Reusable by a future single-cycle normalizer.
- Top module holds the FSM, counter k, y_reg/s_reg/zf and handshake.

Test Plan:
1. D=16, unsigned, x=0x0001, ready_in=1 -> y=0x8000, s=15, zf=0; valid_out exactly 4 edges after accept, then ready_out=1 one edge later.
2. Unsigned x=0x00F0 -> y=0xF000, s=8. Unsigned x=0x8000 -> y=0x8000, s=0, still 4-edge latency.
3. Signed x=0xFFF0 -> y=0x8000, s=11. Signed x=0x0003 -> y=0x6000, s=13. Signed x=0xFFFF -> y=0x8000, s=15.
4. x=0x0000, both modes -> y=0, s=15, zf=1.
5. Backpressure: hold ready_in=0 for 5 cycles in DONE, pulsing valid_in with a new x -> outputs stable, ready_out=0, the new x is not captured; release -> IDLE, a subsequent request is processed correctly.
6. Assert rst_n_in during the second RUN cycle -> immediately all outputs 0 and ready_out=1; after release, x=0x0100 unsigned -> y=0x8000, s=7.
